// File: rtl/dff_chain_loader.sv
// ---------------------------------------------------------------------------
// dff_chain_loader
//
// Sequencing controller that serially loads a WIDTH-bit configuration word
// into an external chain of D flip-flops. The chain captures on the falling
// edge of clk, while this controller updates on the rising edge, so every
// chain-facing output is stable for half a cycle before the chain samples it.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - synchronous, active-low controller reset
//   start      - load request, accepted only while ready=1
//   abort      - cancel request, honoured only in CLEAR or SHIFT
//   cfg_data   - word to load, sampled only on the accepting edge
//   ready      - 1 only when idle
//   busy       - 1 whenever not idle
//   ser_d      - serial data to the chain D input (0 outside SHIFT)
//   shift_en   - chain shift enable (1 only in SHIFT)
//   chain_clr  - drives the chain flop reset pins (CLEAR and ABORT)
//   latch      - one-cycle strobe copying the chain to the holding register
//   done       - one-cycle completion pulse
//   aborted    - one-cycle pulse marking a cancelled load
// ---------------------------------------------------------------------------
module dff_chain_loader #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] cfg_data,
   output logic             ready,
   output logic             busy,
   output logic             ser_d,
   output logic             shift_en,
   output logic             chain_clr,
   output logic             latch,
   output logic             done,
   output logic             aborted
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      LATCH,
      DONE,
      ABORT
   } state_t;

   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   shadow;
   logic [WIDTH-1:0]   shadow_nxt;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic               out_bit_nxt;

   // Next-state, shadow and counter logic. The shadow register always shifts
   // toward the end that feeds ser_d, so the bit to emit next is simply the
   // output-end bit of the shadow. Leaving SHIFT (to LATCH or ABORT) parks the
   // counter at zero so it never runs past WIDTH-1. An abort on the final
   // shift edge wins over the LATCH transition.
   always_comb begin
      state_nxt  = state;
      shadow_nxt = shadow;
      count_nxt  = count;
      case (state)
         IDLE: begin
            if (start) begin
               shadow_nxt = cfg_data;
               count_nxt  = '0;
               state_nxt  = CLEAR;
            end
         end
         CLEAR: begin
            state_nxt = abort ? ABORT : SHIFT;
         end
         SHIFT: begin
            shadow_nxt = MSB_FIRST ? (shadow << 1) : (shadow >> 1);
            if (abort) begin
               state_nxt = ABORT;
               count_nxt = '0;
            end else if (count == LAST_SHIFT) begin
               state_nxt = LATCH;
               count_nxt = '0;
            end else begin
               count_nxt = count + 1'b1;
            end
         end
         LATCH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         ABORT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      out_bit_nxt = MSB_FIRST ? shadow_nxt[WIDTH-1] : shadow_nxt[0];
   end

   // State, shadow, counter and all outputs are registered together. Outputs
   // are decoded from the next state so they line up with the state register
   // and carry no combinational path from the inputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         shadow    <= '0;
         count     <= '0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         ser_d     <= 1'b0;
         shift_en  <= 1'b0;
         chain_clr <= 1'b0;
         latch     <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         state     <= state_nxt;
         shadow    <= shadow_nxt;
         count     <= count_nxt;
         ready     <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         ser_d     <= (state_nxt == SHIFT) && out_bit_nxt;
         shift_en  <= (state_nxt == SHIFT);
         chain_clr <= (state_nxt == CLEAR) || (state_nxt == ABORT);
         latch     <= (state_nxt == LATCH);
         done      <= (state_nxt == DONE);
         aborted   <= (state_nxt == ABORT);
      end
   end

endmodule

// File: tb/tb_dff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_dff_chain_loader
//
// Drives an MSB-first and an LSB-first instance of dff_chain_loader with the
// same stimulus. A timeline model tracks where the current load is, counted
// in cycles since the accepting edge, and derives every expected output from
// that position and the captured word.
// ---------------------------------------------------------------------------
module tb_dff_chain_loader;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         abort;
   logic [W-1:0] cfg_data;

   logic ready_m, busy_m, ser_d_m, shift_en_m, chain_clr_m, latch_m, done_m, aborted_m;
   logic ready_l, busy_l, ser_d_l, shift_en_l, chain_clr_l, latch_l, done_l, aborted_l;

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 = idle, 1 = clear, 2..W+1 = shift, W+2 = latch,
   // W+3 = done, -1 = abort cycle.
   int           phase      = 0;
   logic [W-1:0] word       = '0;
   bit           modelValid = 1'b0;

   dff_chain_loader #(.WIDTH(W), .CNT_W(4), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_data(cfg_data),
      .ready(ready_m), .busy(busy_m), .ser_d(ser_d_m), .shift_en(shift_en_m),
      .chain_clr(chain_clr_m), .latch(latch_m), .done(done_m), .aborted(aborted_m)
   );

   dff_chain_loader #(.WIDTH(W), .CNT_W(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_data(cfg_data),
      .ready(ready_l), .busy(busy_l), .ser_d(ser_d_l), .shift_en(shift_en_l),
      .chain_clr(chain_clr_l), .latch(latch_l), .done(done_l), .aborted(aborted_l)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Expected output vector {ready,busy,ser_d,shift_en,chain_clr,latch,done,aborted}
   // for a given timeline position. The bit sent in shift cycle i is picked
   // straight out of the captured word by index.
   function automatic logic [7:0] expOut(input int ph, input logic [W-1:0] wd, input bit msb);
      logic sd;
      int   i;
      sd = 1'b0;
      if (ph >= 2 && ph <= W + 1) begin
         i  = ph - 2;
         sd = msb ? wd[W-1-i] : wd[i];
      end
      return {ph == 0, ph != 0, sd, (ph >= 2 && ph <= W + 1),
              (ph == 1 || ph == -1), ph == W + 2, ph == W + 3, ph == -1};
   endfunction

   task automatic compareVec(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      compareVec(name, {7'b0, act}, {7'b0, exp});
   endtask

   // Per-cycle comparison of both instances against the model.
   task automatic checkOutput();
      if (modelValid) begin
         compareVec("msb_outputs",
                    {ready_m, busy_m, ser_d_m, shift_en_m, chain_clr_m, latch_m, done_m, aborted_m},
                    expOut(phase, word, 1'b1));
         compareVec("lsb_outputs",
                    {ready_l, busy_l, ser_d_l, shift_en_l, chain_clr_l, latch_l, done_l, aborted_l},
                    expOut(phase, word, 1'b0));
      end
   endtask

   // Drive inputs for the coming rising edge and advance the model timeline
   // to the position the design will occupy after that edge.
   task automatic applyStimulus(input logic r, input logic s, input logic a, input logic [W-1:0] d);
      reset    = r;
      start    = s;
      abort    = a;
      cfg_data = d;
      if (!r) begin
         phase      = 0;
         modelValid = 1'b1;
      end else if (phase == 0) begin
         if (s) begin
            phase = 1;
            word  = d;
         end
      end else if (phase >= 1 && phase <= W + 1 && a) begin
         phase = -1;
      end else if (phase == W + 3 || phase == -1) begin
         phase = 0;
      end else begin
         phase++;
      end
   endtask

   task automatic doCycle(input logic r, input logic s, input logic a, input logic [W-1:0] d);
      applyStimulus(r, s, a, d);
      @(negedge clk);
      checkOutput();
   endtask

   // Directed scenarios followed by a long randomized run.
   initial begin
      int           cur;
      logic         s;
      logic [W-1:0] pat;
      logic [W-1:0] d;

      reset    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      cfg_data = '0;
      pat      = 8'hA5;

      // Reset held with start asserted: stays idle.
      repeat (3) begin
         doCycle(1'b0, 1'b1, 1'b0, 8'hFF);
         checkBit("rst_ready", ready_m, 1'b1);
         checkBit("rst_busy", busy_m, 1'b0);
         checkBit("rst_clr", chain_clr_m, 1'b0);
      end
      doCycle(1'b1, 1'b0, 1'b0, 8'hFF);
      checkBit("release_ready", ready_m, 1'b1);

      // 8'hA5 load with start pulses in cycles 5, 11 and 12.
      doCycle(1'b1, 1'b1, 1'b0, 8'hA5);
      cur = 1;
      checkBit("a5_clear", chain_clr_m, 1'b1);
      compareVec("model_clear", expOut(phase, word, 1'b1), 8'b0100_1000);
      while (cur < 13) begin
         s = (cur == 5 || cur == 11 || cur == 12);
         doCycle(1'b1, s, 1'b0, s ? ((cur == 12) ? 8'h5A : 8'h3C) : 8'h00);
         cur++;
         if (cur >= 2 && cur <= 9) begin
            checkBit("a5_ser", ser_d_m, pat[9-cur]);
            checkBit("a5_shift_en", shift_en_m, 1'b1);
         end
         if (cur == 10) begin
            checkBit("a5_latch", latch_m, 1'b1);
            compareVec("model_latch", expOut(phase, word, 1'b1), 8'b0100_0100);
         end
         if (cur == 11) checkBit("a5_done", done_m, 1'b1);
         if (cur == 12) checkBit("a5_ready", ready_m, 1'b1);
         if (cur == 13) checkBit("second_clear", chain_clr_m, 1'b1);
      end
      repeat (11) begin
         d = 8'($urandom);
         doCycle(1'b1, 1'b0, 1'b0, d);
      end
      checkBit("5a_ready", ready_m, 1'b1);

      // LSB-first load of 8'h01.
      doCycle(1'b1, 1'b1, 1'b0, 8'h01);
      for (int c = 2; c <= 12; c++) begin
         doCycle(1'b1, 1'b0, 1'b0, 8'h00);
         if (c <= 9)  checkBit("lsb_ser", ser_d_l, (c == 2));
         if (c == 10) checkBit("lsb_latch", latch_l, 1'b1);
         if (c == 11) checkBit("lsb_done", done_l, 1'b1);
         if (c == 12) checkBit("lsb_ready", ready_l, 1'b1);
      end

      // Abort in the 4th shift cycle.
      doCycle(1'b1, 1'b1, 1'b0, 8'hFF);
      repeat (4) doCycle(1'b1, 1'b0, 1'b0, 8'h00);
      doCycle(1'b1, 1'b0, 1'b1, 8'h00);
      checkBit("abort_flag", aborted_m, 1'b1);
      checkBit("abort_clr", chain_clr_m, 1'b1);
      checkBit("abort_shift_en", shift_en_m, 1'b0);
      doCycle(1'b1, 1'b0, 1'b0, 8'h00);
      checkBit("abort_ready", ready_m, 1'b1);

      // Abort in the 8th (final) shift cycle overrides the latch.
      doCycle(1'b1, 1'b1, 1'b0, 8'hFF);
      repeat (8) doCycle(1'b1, 1'b0, 1'b0, 8'h00);
      doCycle(1'b1, 1'b0, 1'b1, 8'h00);
      checkBit("late_abort_flag", aborted_m, 1'b1);
      checkBit("late_abort_latch", latch_m, 1'b0);
      doCycle(1'b1, 1'b0, 1'b0, 8'h00);

      // Reset in cycle 4 of a load, then a load started with abort also high.
      doCycle(1'b1, 1'b1, 1'b0, 8'hFF);
      repeat (3) doCycle(1'b1, 1'b0, 1'b0, 8'h00);
      doCycle(1'b0, 1'b0, 1'b0, 8'h00);
      checkBit("midrst_ready", ready_m, 1'b1);
      checkBit("midrst_shift_en", shift_en_m, 1'b0);
      checkBit("midrst_ser", ser_d_m, 1'b0);
      doCycle(1'b1, 1'b1, 1'b1, 8'hC3);
      checkBit("start_abort_clr", chain_clr_m, 1'b1);
      checkBit("start_abort_flag", aborted_m, 1'b0);
      repeat (11) doCycle(1'b1, 1'b0, 1'b0, 8'h00);
      checkBit("c3_ready", ready_m, 1'b1);

      // Randomized traffic.
      repeat (3000) begin
         d = 8'($urandom);
         doCycle(($urandom_range(63) != 0), ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0), d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
